// File: rtl/alu_vector_checker_if.sv
// Bus between the vector checker and the 4-bit add/sub ALU under test.
// The checker drives operands/mode/carry-in and samples result and flags.
interface alu_vector_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_add_sub;
  logic             alu_c0;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c4;
  logic             alu_zf;
  logic             alu_cf;

  modport master (
    output alu_a, alu_b, alu_add_sub, alu_c0,
    input  alu_f, alu_c4, alu_zf, alu_cf
  );

  modport slave (
    input  alu_a, alu_b, alu_add_sub, alu_c0,
    output alu_f, alu_c4, alu_zf, alu_cf
  );
endinterface

// File: rtl/alu_vector_checker.sv
// Exhaustive stimulus/response checker for a WIDTH-bit add/sub ALU.
// Sweeps every {c0,add_sub,a,b} vector, compares against a golden model, logs the first failure.
module alu_vector_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  alu_vector_checker_if.master   alu,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   fail_valid,
  output logic [2*WIDTH+1:0]     fail_vec,
  output logic [WIDTH+2:0]       fail_got
);

  localparam int VEC_W = 2 * WIDTH + 2;
  localparam int RES_W = WIDTH + 3;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VEC_W-1:0] LAST_VEC = {VEC_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   drv_q, drv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic [RES_W-1:0]   fail_got_q, fail_got_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [RES_W-1:0]   got;
  logic               mismatch;

  // Golden result {c4,zf,cf,f}; subtraction is A + ~B + C0 so CF is the inverted carry.
  function automatic logic [RES_W-1:0] golden(input logic [VEC_W-1:0] v);
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    b_op = v[2*WIDTH] ? ~v[WIDTH-1:0] : v[WIDTH-1:0];
    sum  = {1'b0, v[2*WIDTH-1:WIDTH]} + {1'b0, b_op} + {{WIDTH{1'b0}}, v[2*WIDTH+1]};
    return {sum[WIDTH], (sum[WIDTH-1:0] == '0), sum[WIDTH] ^ v[2*WIDTH], sum[WIDTH-1:0]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + ERR_W'(1);
  endfunction

  assign got      = {alu.alu_c4, alu.alu_zf, alu.alu_cf, alu.alu_f};
  assign mismatch = (got != golden(drv_q));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    drv_d        = drv_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_got_d   = fail_got_q;
    done_d       = done_q;
    pass_d       = pass_q;

    if (abort) begin
      // Results of the interrupted sweep stay visible; only the bus and status clear.
      state_d = S_IDLE;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      drv_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_APPLY;
            vec_d        = '0;
            err_d        = '0;
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
            fail_got_d   = '0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
          end
        end
        S_APPLY: begin
          drv_d   = vec_q;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_CHECK;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = drv_q;
              fail_got_d   = got;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            state_d = S_APPLY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      drv_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      drv_q        <= drv_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign alu.alu_b       = drv_q[WIDTH-1:0];
  assign alu.alu_a       = drv_q[2*WIDTH-1:WIDTH];
  assign alu.alu_add_sub = drv_q[2*WIDTH];
  assign alu.alu_c0      = drv_q[2*WIDTH+1];

  assign busy       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: an arithmetic ALU model with injectable faults feeds two checkers
// (11-bit and saturating 4-bit error counters); expectations come from plain-integer add/sub rules.
module tb_alu_vector_checker;
  localparam int W     = 4;
  localparam int SET   = 2;
  localparam int NV    = 1 << (2 * W + 2);
  localparam int SWEEP = NV * (SET + 2);
  localparam int LIMIT = SWEEP + 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_vector_checker_if #(.WIDTH(W)) bus ();
  alu_vector_checker_if #(.WIDTH(W)) bus4 ();

  logic              busy, done, pass, fail_valid;
  logic [10:0]       err_cnt;
  logic [2*W+1:0]    fail_vec;
  logic [W+2:0]      fail_got;
  logic              busy4, done4, pass4, fail_valid4;
  logic [3:0]        err_cnt4;
  logic [2*W+1:0]    fail_vec4;
  logic [W+2:0]      fail_got4;

  alu_vector_checker #(.WIDTH(W), .SETTLE(SET), .ERR_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu(bus.master),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_got(fail_got)
  );

  alu_vector_checker #(.WIDTH(W), .SETTLE(SET), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu(bus4.master),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err_cnt4),
    .fail_valid(fail_valid4), .fail_vec(fail_vec4), .fail_got(fail_got4)
  );

  // Reference ALU behaviour: {c4,zf,cf,f} from plain integer arithmetic.
  function automatic logic [W+2:0] alu_ref(input int v);
    int m, b, a, as, c0, r;
    logic [31:0] rv;
    logic c4;
    m  = 1 << W;
    b  = v % m;
    a  = (v / m) % m;
    as = (v / (m * m)) % 2;
    c0 = v / (m * m * 2);
    r  = (as != 0) ? a + (m - 1 - b) + c0 : a + b + c0;
    rv = r;
    c4 = (r >= m);
    return {c4, (r % m) == 0, c4 ^ (as != 0), rv[W-1:0]};
  endfunction

  int            fault_mode = 0;
  logic          bad [NV];
  logic [W+2:0]  mask [NV];
  logic [2*W+1:0] bus_v, bus4_v;
  logic [W+2:0]  alu_o, alu4_o;

  always_comb begin
    bus_v = {bus.alu_c0, bus.alu_add_sub, bus.alu_a, bus.alu_b};
    alu_o = alu_ref(int'(bus_v));
    if (fault_mode == 1)      alu_o[W+1] = 1'b0;
    else if (fault_mode == 2) alu_o[W]   = ~alu_o[W];
    else if (fault_mode == 3 && bad[bus_v]) alu_o = alu_o ^ mask[bus_v];
  end
  assign {bus.alu_c4, bus.alu_zf, bus.alu_cf, bus.alu_f} = alu_o;

  always_comb begin
    bus4_v = {bus4.alu_c0, bus4.alu_add_sub, bus4.alu_a, bus4.alu_b};
    alu4_o = alu_ref(int'(bus4_v));
    alu4_o[W] = ~alu4_o[W];
  end
  assign {bus4.alu_c4, bus4.alu_zf, bus4.alu_cf, bus4.alu_f} = alu4_o;

  task automatic begin_sweep();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, err_cnt, fail_valid, fail_vec, fail_got, bus_v} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {busy, done, pass, err_cnt, fail_valid, fail_vec, fail_got, bus_v});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_correct();
    int n;
    fault_mode = 0;
    begin_sweep();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b exp 1", busy); end
    wait_done(n);
    checks++;
    if (n != SWEEP) begin errors++; $display("FAIL correct_cycles got %0d exp %0d", n, SWEEP); end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 11'd0 || fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL correct_result got pass=%b err=%0d fv=%b exp 1 0 0", pass, err_cnt, fail_valid);
    end
    checks++;
    if (busy !== 1'b0 || bus_v !== 10'h3FF) begin
      errors++;
      $display("FAIL correct_hold got busy=%b vec=%h exp 0 3ff", busy, bus_v);
    end
  endtask

  task automatic test_zf_stuck();
    int n;
    fault_mode = 1;
    begin_sweep();
    wait_done(n);
    checks++;
    if (err_cnt !== 11'd64 || pass !== 1'b0) begin
      errors++;
      $display("FAIL zf_stuck_count got err=%0d pass=%b exp 64 0", err_cnt, pass);
    end
    checks++;
    if (fail_valid !== 1'b1 || fail_vec !== '0 || fail_got !== 7'b0000000) begin
      errors++;
      $display("FAIL zf_stuck_first got fv=%b vec=%h res=%b exp 1 0 0000000", fail_valid, fail_vec, fail_got);
    end
  endtask

  task automatic test_cf_inverted();
    int n;
    fault_mode = 2;
    begin_sweep();
    wait_done(n);
    checks++;
    if (err_cnt !== 11'd1024 || pass !== 1'b0 || fail_vec !== '0) begin
      errors++;
      $display("FAIL cf_inv got err=%0d pass=%b vec=%h exp 1024 0 0", err_cnt, pass, fail_vec);
    end
    checks++;
    if (fail_got !== (alu_ref(0) ^ 7'b0010000)) begin
      errors++;
      $display("FAIL cf_inv_got got %b exp %b", fail_got, alu_ref(0) ^ 7'b0010000);
    end
    checks++;
    if (done4 !== 1'b1 || err_cnt4 !== 4'd15 || fail_valid4 !== 1'b1 || pass4 !== 1'b0) begin
      errors++;
      $display("FAIL err_saturate got done=%b err=%0d fv=%b pass=%b exp 1 15 1 0", done4, err_cnt4, fail_valid4, pass4);
    end
  endtask

  task automatic test_random_faults();
    int n, cnt, first;
    logic [W+2:0] exp_got;
    for (int rep = 0; rep < 2; rep++) begin
      cnt = 0;
      first = -1;
      for (int i = 0; i < NV; i++) begin
        bad[i]  = ($urandom_range(0, 40) == 0);
        mask[i] = 7'($urandom_range(1, 127));
      end
      bad[$urandom_range(0, NV - 1)] = 1'b1;
      for (int i = 0; i < NV; i++) if (bad[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
      exp_got = alu_ref(first) ^ mask[first];
      fault_mode = 3;
      begin_sweep();
      wait_done(n);
      checks++;
      if (err_cnt !== 11'(cnt) || pass !== 1'b0) begin
        errors++;
        $display("FAIL rand_count got err=%0d pass=%b exp %0d 0", err_cnt, pass, cnt);
      end
      checks++;
      if (fail_valid !== 1'b1 || fail_vec !== 10'(first) || fail_got !== exp_got) begin
        errors++;
        $display("FAIL rand_first got vec=%0d res=%b exp %0d %b", fail_vec, fail_got, first, exp_got);
      end
    end
    fault_mode = 0;
  endtask

  task automatic test_abort();
    int n, zc;
    fault_mode = 1;
    begin_sweep();
    n = 0;
    while (bus_v !== 10'd300 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    zc = 0;
    for (int v = 0; v < 300; v++) if (alu_ref(v) % (1 << W) == 0) zc++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || bus_v !== '0) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b pass=%b vec=%h exp 0 0 0 0", busy, done, pass, bus_v);
    end
    checks++;
    if (err_cnt !== 11'(zc) || fail_valid !== 1'b1 || fail_vec !== '0) begin
      errors++;
      $display("FAIL abort_keep got err=%0d fv=%b vec=%h exp %0d 1 0", err_cnt, fail_valid, fail_vec, zc);
    end
    fault_mode = 0;
    begin_sweep();
    checks++;
    if (err_cnt !== 11'd0 || fail_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got err=%0d fv=%b busy=%b exp 0 0 1", err_cnt, fail_valid, busy);
    end
    wait_done(n);
    checks++;
    if (n != SWEEP || pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_sweep got cycles=%0d pass=%b exp %0d 1", n, pass, SWEEP);
    end
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins got busy=%b done=%b pass=%b exp 0 0 0", busy, done, pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    begin_sweep();
    repeat (41) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, err_cnt, fail_valid, fail_vec, fail_got, bus_v} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {busy, done, pass, err_cnt, fail_valid, fail_vec, fail_got, bus_v});
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus_v !== '0) begin
      errors++;
      $display("FAIL reset_release got busy=%b vec=%h exp 0 0", busy, bus_v);
    end
  endtask

  task automatic test_start_while_busy();
    int n, p1, p2;
    p1 = $urandom_range(1, 2000);
    p2 = $urandom_range(2001, SWEEP - 2);
    fault_mode = 0;
    begin_sweep();
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      start = (n == p1 || n == p2 || n == 5);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (n != SWEEP || pass !== 1'b1 || err_cnt !== 11'd0) begin
      errors++;
      $display("FAIL start_while_busy got cycles=%0d pass=%b err=%0d exp %0d 1 0", n, pass, err_cnt, SWEEP);
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      bad[i]  = 1'b0;
      mask[i] = '0;
    end
    #2;
    test_reset();
    test_correct();
    test_zf_stuck();
    test_cf_inverted();
    test_random_faults();
    test_abort();
    test_reset_mid_sweep();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
